// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register, word-organised data memory with sub-word access,
// branch/jump resolution, misalignment detection and the MEM/WB register.
module memory_stage #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ex_Zero,
  input  logic [31:0] ex_ALUResult,
  input  logic [31:0] ex_PC_Plus_Branch,
  input  logic [27:0] ex_j_sll_two,
  input  logic [31:0] ex_PCPlusFour,
  input  logic [4:0]  ex_RegDest,
  input  logic [31:0] ex_StoreData,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic [1:0]  ex_MemSize,
  input  logic        ex_MemSigned,
  input  logic [1:0]  ex_Branch,
  input  logic        ex_Jump,
  input  logic        ex_RegWrite,
  input  logic        ex_MemToReg,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_RegDest,
  output logic [31:0] wb_Data,
  output logic        MisalignFault
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Sub-word load: pick the addressed lane and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b01:   return {{16{sgn & h[15]}}, h};
      2'b10:   return {{24{sgn & b[7]}}, b};
      default: return w;
    endcase
  endfunction

  // Sub-word store: replace only the addressed lanes of the current word.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] s,
                                              input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b01:   return a[1] ? {s[15:0], w[15:0]} : {w[31:16], s[15:0]};
      2'b10: begin
        case (a)
          2'd0:    return {w[31:8], s[7:0]};
          2'd1:    return {w[31:16], s[7:0], w[7:0]};
          2'd2:    return {w[31:24], s[7:0], w[15:0]};
          default: return {s[7:0], w[23:0]};
        endcase
      end
      default: return s;
    endcase
  endfunction

  logic        r_em_zero, r_em_mrd, r_em_mwr, r_em_msigned, r_em_jump, r_em_regwr, r_em_m2r;
  logic [31:0] r_em_alu, r_em_pcb, r_em_sdata;
  logic [27:0] r_em_jidx;
  logic [3:0]  r_em_pc4_hi;
  logic [4:0]  r_em_rd;
  logic [1:0]  r_em_size, r_em_branch;

  logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

  logic        r_wb_regwr, r_fault;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0] w_word, w_load, w_wr_word;
  logic        w_is_sub, w_misalign, w_taken;
  logic [27:0] w_unused_pc4;

  assign w_unused_pc4 = ex_PCPlusFour[27:0];

  // EX/MEM boundary: Flush keeps data but turns the instruction into a bubble, even under Stall
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_em_zero <= 1'b0; r_em_alu <= '0; r_em_pcb <= '0; r_em_jidx <= '0; r_em_pc4_hi <= '0;
      r_em_rd <= '0; r_em_sdata <= '0; r_em_mrd <= 1'b0; r_em_mwr <= 1'b0; r_em_size <= '0;
      r_em_msigned <= 1'b0; r_em_branch <= '0; r_em_jump <= 1'b0; r_em_regwr <= 1'b0;
      r_em_m2r <= 1'b0;
    end else if (Flush || !Stall) begin
      r_em_zero    <= ex_Zero;
      r_em_alu     <= ex_ALUResult;
      r_em_pcb     <= ex_PC_Plus_Branch;
      r_em_jidx    <= ex_j_sll_two;
      r_em_pc4_hi  <= ex_PCPlusFour[31:28];
      r_em_rd      <= ex_RegDest;
      r_em_sdata   <= ex_StoreData;
      r_em_size    <= ex_MemSize;
      r_em_msigned <= ex_MemSigned;
      r_em_m2r     <= ex_MemToReg;
      r_em_mrd     <= Flush ? 1'b0 : ex_MemRead;
      r_em_mwr     <= Flush ? 1'b0 : ex_MemWrite;
      r_em_branch  <= Flush ? 2'b00 : ex_Branch;
      r_em_jump    <= Flush ? 1'b0 : ex_Jump;
      r_em_regwr   <= Flush ? 1'b0 : ex_RegWrite;
    end
  end

  assign w_idx      = r_em_alu[ADDR_WIDTH+1:2];
  assign w_word     = r_mem[w_idx];
  assign w_is_sub   = (r_em_size == 2'b01) || (r_em_size == 2'b10);
  assign w_misalign = (r_em_mrd | r_em_mwr) &
                      (((r_em_size == 2'b01) & r_em_alu[0]) | (!w_is_sub & (r_em_alu[1:0] != 2'b00)));
  assign w_load     = w_misalign ? 32'h0 : load_extract(w_word, r_em_alu[1:0], r_em_size, r_em_msigned);
  assign w_wr_word  = store_merge(w_word, r_em_sdata, r_em_alu[1:0], r_em_size);

  assign w_taken      = ((r_em_branch == 2'b01) & r_em_zero) | ((r_em_branch == 2'b10) & ~r_em_zero);
  assign PCSrc        = r_em_jump | w_taken;
  assign BranchTarget = r_em_jump ? {r_em_pc4_hi, r_em_jidx} : r_em_pcb;

  always_ff @(posedge Clk) begin
    if (!Reset && !Stall && r_em_mwr && !w_misalign) r_mem[w_idx] <= w_wr_word;
  end

  // MEM/WB boundary
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wb_regwr <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (w_misalign) r_fault <= 1'b1;
      if (!Stall) begin
        r_wb_regwr <= r_em_regwr & ~w_misalign;
        r_wb_rd    <= r_em_rd;
        r_wb_data  <= r_em_m2r ? w_load : r_em_alu;
      end
    end
  end

  assign wb_RegWrite   = r_wb_regwr;
  assign wb_RegDest    = r_wb_rd;
  assign wb_Data       = r_wb_data;
  assign MisalignFault = r_fault;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads/stores, sub-word access, branches,
// misalignment, stall/flush and reset behaviour against hand-computed values.
module tb_memory_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush;
  logic        ex_Zero;
  logic [31:0] ex_ALUResult, ex_PC_Plus_Branch, ex_PCPlusFour, ex_StoreData;
  logic [27:0] ex_j_sll_two;
  logic [4:0]  ex_RegDest;
  logic        ex_MemRead, ex_MemWrite, ex_MemSigned, ex_Jump, ex_RegWrite, ex_MemToReg;
  logic [1:0]  ex_MemSize, ex_Branch;
  logic        PCSrc, wb_RegWrite, MisalignFault;
  logic [31:0] BranchTarget, wb_Data;
  logic [4:0]  wb_RegDest;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(.ADDR_WIDTH(10)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ex_Zero(ex_Zero), .ex_ALUResult(ex_ALUResult), .ex_PC_Plus_Branch(ex_PC_Plus_Branch),
    .ex_j_sll_two(ex_j_sll_two), .ex_PCPlusFour(ex_PCPlusFour), .ex_RegDest(ex_RegDest),
    .ex_StoreData(ex_StoreData), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemSize(ex_MemSize), .ex_MemSigned(ex_MemSigned), .ex_Branch(ex_Branch),
    .ex_Jump(ex_Jump), .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .wb_RegWrite(wb_RegWrite),
    .wb_RegDest(wb_RegDest), .wb_Data(wb_Data), .MisalignFault(MisalignFault)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_nop();
    ex_Zero = 1'b0; ex_ALUResult = '0; ex_PC_Plus_Branch = '0; ex_PCPlusFour = '0;
    ex_StoreData = '0; ex_j_sll_two = '0; ex_RegDest = '0; ex_MemRead = 1'b0;
    ex_MemWrite = 1'b0; ex_MemSigned = 1'b0; ex_Jump = 1'b0; ex_RegWrite = 1'b0;
    ex_MemToReg = 1'b0; ex_MemSize = 2'b00; ex_Branch = 2'b00;
  endtask

  // Present a store and let EX/MEM capture it; the write lands on the following edge.
  task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    set_nop();
    ex_MemWrite = 1'b1; ex_ALUResult = addr; ex_StoreData = data; ex_MemSize = sz;
    tick();
  endtask

  // Present a load, then a bubble; wb_* is valid after the second edge.
  task automatic ld(input logic [31:0] addr, input logic [1:0] sz, input logic sgn,
                    input logic [4:0] rd);
    set_nop();
    ex_MemRead = 1'b1; ex_MemToReg = 1'b1; ex_RegWrite = 1'b1;
    ex_ALUResult = addr; ex_MemSize = sz; ex_MemSigned = sgn; ex_RegDest = rd;
    tick();
    set_nop();
    tick();
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    set_nop();
    tick(); tick();
    Reset = 1'b0;
    check("rst_pcsrc", {31'b0, PCSrc}, 32'h0);
    check("rst_target", BranchTarget, 32'h0);
    check("rst_regwrite", {31'b0, wb_RegWrite}, 32'h0);
    check("rst_regdest", {27'b0, wb_RegDest}, 32'h0);
    check("rst_data", wb_Data, 32'h0);
    check("rst_fault", {31'b0, MisalignFault}, 32'h0);

    // Word store then load
    st(32'h10, 32'hDEADBEEF, 2'b00);
    ld(32'h10, 2'b00, 1'b0, 5'd5);
    check("lw_data", wb_Data, 32'hDEADBEEF);
    check("lw_regwrite", {31'b0, wb_RegWrite}, 32'h1);
    check("lw_regdest", {27'b0, wb_RegDest}, 32'd5);

    // Byte store to the top lane, sub-word loads
    st(32'h13, 32'h12345680, 2'b10);
    ld(32'h13, 2'b10, 1'b1, 5'd6);
    check("lb_signed", wb_Data, 32'hFFFFFF80);
    ld(32'h13, 2'b10, 1'b0, 5'd6);
    check("lbu", wb_Data, 32'h00000080);
    ld(32'h10, 2'b00, 1'b0, 5'd6);
    check("lw_after_sb", wb_Data, 32'h80ADBEEF);
    ld(32'h12, 2'b01, 1'b1, 5'd6);
    check("lh_signed_hi", wb_Data, 32'hFFFF80AD);
    ld(32'h10, 2'b01, 1'b0, 5'd6);
    check("lhu_lo", wb_Data, 32'h0000BEEF);

    // ALU result write-back
    set_nop();
    ex_RegWrite = 1'b1; ex_RegDest = 5'd4; ex_ALUResult = 32'h00001234;
    tick(); set_nop(); tick();
    check("alu_data", wb_Data, 32'h00001234);
    check("alu_regdest", {27'b0, wb_RegDest}, 32'd4);

    // Branches and jump
    set_nop();
    ex_Branch = 2'b01; ex_Zero = 1'b1; ex_PC_Plus_Branch = 32'h40;
    tick();
    check("beq_pcsrc", {31'b0, PCSrc}, 32'h1);
    check("beq_target", BranchTarget, 32'h40);
    ex_Branch = 2'b10;
    tick();
    check("bne_pcsrc", {31'b0, PCSrc}, 32'h0);
    check("bne_target", BranchTarget, 32'h40);
    ex_Branch = 2'b01; ex_Jump = 1'b1; ex_PCPlusFour = 32'h30000004; ex_j_sll_two = 28'h0000100;
    tick();
    check("jump_target", BranchTarget, 32'h30000100);
    check("jump_pcsrc", {31'b0, PCSrc}, 32'h1);
    ex_Jump = 1'b0; ex_Branch = 2'b01; Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_beq_pcsrc", {31'b0, PCSrc}, 32'h0);
    check("flush_beq_target", BranchTarget, 32'h40);

    // Misaligned halfword store: suppressed, fault is sticky
    st(32'h11, 32'h0000FFFF, 2'b01);
    check("fault_not_yet", {31'b0, MisalignFault}, 32'h0);
    ld(32'h10, 2'b00, 1'b0, 5'd8);
    check("mis_sh_nowrite", wb_Data, 32'h80ADBEEF);
    check("fault_set", {31'b0, MisalignFault}, 32'h1);
    ld(32'h12, 2'b00, 1'b0, 5'd7);
    check("mis_lw_regwrite", {31'b0, wb_RegWrite}, 32'h0);
    check("mis_lw_data", wb_Data, 32'h0);

    // Address wrap modulo 4 KiB
    st(32'h00001010, 32'hCAFEF00D, 2'b00);
    ld(32'h10, 2'b00, 1'b0, 5'd9);
    check("wrap_lw", wb_Data, 32'hCAFEF00D);
    check("fault_held", {31'b0, MisalignFault}, 32'h1);

    // Store held by Stall, written once on release; then Flush+Stall bubbles an ALU op
    st(32'h20, 32'h11111111, 2'b00);
    Stall = 1'b1;
    set_nop();
    tick(); tick(); tick();
    Stall = 1'b0;
    ex_RegWrite = 1'b1; ex_RegDest = 5'd9; ex_ALUResult = 32'h55;
    tick();
    Stall = 1'b1; Flush = 1'b1;
    set_nop();
    tick();
    Stall = 1'b0; Flush = 1'b0;
    tick();
    check("flush_stall_regwrite", {31'b0, wb_RegWrite}, 32'h0);
    ld(32'h20, 2'b00, 1'b0, 5'd10);
    check("stalled_store", wb_Data, 32'h11111111);

    // Store stalled then flushed never reaches memory
    st(32'h24, 32'h22222222, 2'b00);
    Stall = 1'b1;
    set_nop();
    tick(); tick();
    Flush = 1'b1;
    tick();
    Stall = 1'b0; Flush = 1'b0;
    ld(32'h24, 2'b00, 1'b0, 5'd11);
    check("flushed_store", wb_Data, 32'h0);

    // Reset drops a pending store and clears the fault
    st(32'h28, 32'h33333333, 2'b00);
    Reset = 1'b1;
    set_nop();
    tick();
    Reset = 1'b0;
    check("rst2_fault", {31'b0, MisalignFault}, 32'h0);
    check("rst2_data", wb_Data, 32'h0);
    ld(32'h28, 2'b00, 1'b0, 5'd12);
    check("rst_dropped_store", wb_Data, 32'h0);
    ld(32'h10, 2'b00, 1'b0, 5'd12);
    check("mem_kept_over_rst", wb_Data, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
